// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch on port 0, load/store on port 1),
// the arbiter, and the unified word-addressed memory.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          req0;
  logic          we0;
  logic [AW-1:0] addr0;
  logic [DW-1:0] wdata0;
  logic          ack0;
  logic [DW-1:0] rdata0;

  logic          req1;
  logic          we1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] wdata1;
  logic          ack1;
  logic [DW-1:0] rdata1;

  logic          MemRead;
  logic          MemWrite;
  logic [AW-1:0] Address;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ReadData,
    output ack0, rdata0, ack1, rdata1,
    output MemRead, MemWrite, Address, WriteData
  );

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ReadData,
    input  ack0, rdata0, ack1, rdata1,
    input  MemRead, MemWrite, Address, WriteData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter that serialises fetch and load/store accesses
// onto one memory, holding the controls for LATENCY cycles per access.
//
//   state | meaning
//   IDLE  | no access; arbitrate pending requests
//   BUSY  | memory controls driven, cnt counts down to 0
//   RESP  | one-cycle ack to the served port, record it as last grant
module mem_arbiter #(
  parameter int LATENCY = 1,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          id_q, id_d;
  logic          we_q, we_d;
  logic          last_gnt_q, last_gnt_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata0_q, rdata0_d;
  logic [DW-1:0] rdata1_q, rdata1_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          gnt;
  logic          busy;
  logic          cnt_zero;

  assign busy     = (state_q == BUSY);
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    we_d       = we_q;
    last_gnt_d = last_gnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata0_d   = rdata0_q;
    rdata1_d   = rdata1_q;
    cnt_d      = cnt_q;
    ack0_d     = 1'b0;
    ack1_d     = 1'b0;
    // On a tie the port that did not win last time is served.
    gnt        = (bus.req0 & bus.req1) ? ~last_gnt_q : bus.req1;

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          id_d    = gnt;
          we_d    = gnt ? bus.we1    : bus.we0;
          addr_d  = gnt ? bus.addr1  : bus.addr0;
          wdata_d = gnt ? bus.wdata1 : bus.wdata0;
          cnt_d   = CW'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_zero) begin
          if (!we_q) begin
            if (id_q) rdata1_d = bus.ReadData;
            else      rdata0_d = bus.ReadData;
          end
          ack0_d  = ~id_q;
          ack1_d  = id_q;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        last_gnt_d = id_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      id_q       <= 1'b0;
      we_q       <= 1'b0;
      last_gnt_q <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata0_q   <= '0;
      rdata1_q   <= '0;
      cnt_q      <= '0;
      ack0_q     <= 1'b0;
      ack1_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      we_q       <= we_d;
      last_gnt_q <= last_gnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata0_q   <= rdata0_d;
      rdata1_q   <= rdata1_d;
      cnt_q      <= cnt_d;
      ack0_q     <= ack0_d;
      ack1_q     <= ack1_d;
    end
  end

  // Gating with rst keeps an aborted access from writing memory or acking.
  assign bus.ack0      = ack0_q & ~rst;
  assign bus.ack1      = ack1_q & ~rst;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.MemRead   = busy & ~we_q;
  assign bus.MemWrite  = busy & we_q & cnt_zero & ~rst;
  assign bus.Address   = busy ? addr_q  : '0;
  assign bus.WriteData = busy ? wdata_q : '0;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Two-requester arbiter and sequencer for the single unified word-addressed Memory in the multi-cycle MIPS. Port 0 serves instruction fetch and port 1 serves data load/store. The block serialises accesses, drives MemRead/MemWrite/Address/WriteData with a programmable access latency, and returns read data with a one-cycle ack pulse. Round-robin fairness applies on simultaneous requests.

Parameters:
LATENCY, 1, cycles the memory controls are held per access (min 1)
AW, 32, address width
DW, 32, data width

Ports:
clk  input  1  system clock, all state on posedge
rst  input  1  synchronous active-high reset
req0  input  1  port 0 (fetch) request, held until ack0
we0  input  1  port 0 write enable (0 = read)
addr0  input  AW  port 0 word address
wdata0  input  DW  port 0 write data
ack0  output  1  one-cycle completion pulse, port 0
rdata0  output  DW  port 0 read data, valid with ack0, held afterwards
req1  input  1  port 1 (data) request, held until ack1
we1  input  1  port 1 write enable
addr1  input  AW  port 1 word address
wdata1  input  DW  port 1 write data
ack1  output  1  completion pulse, port 1
rdata1  output  DW  port 1 read data
MemRead  output  1  to Memory
MemWrite  output  1  to Memory
Address  output  AW  to Memory
WriteData  output  DW  to Memory
ReadData  input  DW  from Memory (combinational read)

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high.
- States: IDLE, BUSY, RESP. Registers: state, id_q, we_q, addr_q, wdata_q, cnt (ceil(log2(LATENCY+1)) bits), last_gnt, rdata0_q, rdata1_q.
- Reset values (at a posedge with rst=1):
  - state=IDLE, last_gnt=1 (port 0 wins the first tie).
  - cnt=0, rdata0=rdata1=0, ack0=ack1=0.
  - addr_q, wdata_q, we_q, id_q = 0.
- IDLE:
  - No req: stay in IDLE.
  - Only one req: grant it.
  - Both req: grant the port != last_gnt.
  - On grant: latch id/we/addr/wdata of the winner, cnt<=LATENCY-1, go to BUSY.
  - No memory controls are driven in IDLE.
- BUSY:
  - Address=addr_q and WriteData=wdata_q.
  - MemRead = ~we_q for every BUSY cycle.
  - MemWrite = we_q & (cnt==0) & ~rst, so exactly one write edge per access and never a write on a reset edge.
  - cnt decrements each cycle.
  - When cnt==0: for a read, capture ReadData into rdata[id_q]_q; go to RESP.
- RESP:
  - ack[id_q]=1 for exactly this cycle; last_gnt<=id_q; go to IDLE.
  - MemRead=MemWrite=0.
  - Write accesses leave rdataN unchanged.
- Outside BUSY: Address and WriteData drive 0, MemRead=MemWrite=0.
- Latency: req sampled high in IDLE at cycle t → BUSY cycles t+1..t+LATENCY → ackN high in cycle t+LATENCY+1. Back-to-back throughput is one access per LATENCY+2 cycles.
- Handshake:
  - Requester holds req/we/addr/wdata stable until it samples ack.
  - Requester clears req at the posedge where ack=1.
  - Inputs of the granted port are ignored after the grant cycle. A change mid-access has no effect.
  - A req raised during BUSY/RESP by either port waits and is arbitrated in the next IDLE cycle.
- Fairness: with both req held continuously, grants alternate 0,1,0,1…, and neither port waits more than one other access.
- Reset mid-access (BUSY or RESP): the access is aborted and no ack is issued. No write reaches memory on the reset edge. The FSM is in IDLE the cycle after.
- ack0 and ack1 are never high together. MemRead and MemWrite are never high together.
- Addresses pass through unmodified (word addressing). Range checking belongs to Memory.

Test Plan:
- Reset then req0=1,we0=0,addr0=5 (Data[5]=0xDEADBEEF), LATENCY=1 → MemRead=1,Address=5 in cycle 1; ack0=1,rdata0=0xDEADBEEF in cycle 2; rdata0 stays until next port-0 read.
- req1=1,we1=1,addr1=100,wdata1=0x12345678, LATENCY=3 → MemWrite high only on 3rd BUSY cycle; ack1 in cycle 4; subsequent port-1 read of 100 returns 0x12345678; rdata1 unchanged by the write.
- req0 and req1 raised together from reset, both held and re-raised after each ack, 4 accesses → grant order 0,1,0,1; acks spaced LATENCY+2 cycles; never simultaneous.
- req1 raised while a port-0 access is in BUSY → port-1 access starts in first IDLE after ack0; port-0 address change during BUSY does not alter Address.
- rst asserted during the final BUSY cycle of a write to addr 7, LATENCY=2 → MemWrite=0 that cycle; Data[7] unchanged; no ack1; state IDLE, outputs 0 next cycle.
- Single req0 with req1=0 repeatedly (5 reads) → port 0 served every LATENCY+2 cycles without stalls despite last_gnt=0.
